fp_adder_pack_result: RTL

//  Final stage of the floating point adder; the output-side counterpart of the stage-1 special classifier.

---
 rtl/fp_adder_pack_result.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fp_adder_pack_result.sv
// ============================================================================
// Module      : fp_adder_pack_result
// Description : Final floating point adder stage. It applies round-to-nearest-
//               even, packs the IEEE result word and exception flags, and
//               delivers them through a 2-entry valid/ready output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_adder_pack_result #(
    parameter int DATA_FORMAT = 0,   // 0: FP32, 1: FP64, 2: FP16
    localparam int E = (DATA_FORMAT == 1) ? 11 : (DATA_FORMAT == 2) ? 5 : 8,
    localparam int M = (DATA_FORMAT == 1) ? 52 : (DATA_FORMAT == 2) ? 10 : 23,
    localparam int W = 1 + E + M
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     special,
    input  logic           a_sign,
    input  logic           b_sign,
    input  logic           a_is_inf,
    input  logic           norm_sign,
    input  logic [E+1:0]   norm_exp,
    input  logic [M+3:0]   norm_mant,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic [2:0]     out_flags
);

    // Stage-1 classifier codes
    localparam logic [1:0] C_SP_NORMAL = 2'd0;
    localparam logic [1:0] C_SP_ZERO   = 2'd1;
    localparam logic [1:0] C_SP_INF    = 2'd2;

    localparam logic [E+1:0] C_EXP_MAX = {2'b00, {E{1'b1}}};

    logic             w_lsb;
    logic             w_guard;
    logic             w_rs;
    logic             w_inexact;
    logic             w_round_up;
    logic [M+1:0]     w_sig;
    logic [E+2:0]     w_exp_r;
    logic [M-1:0]     w_frac;
    logic             w_ovf;
    logic             w_unf;
    logic [W-1:0]     w_word;
    logic [2:0]       w_flags;

    always_comb begin
        w_lsb      = norm_mant[3];
        w_guard    = norm_mant[2];
        w_rs       = norm_mant[1] | norm_mant[0];
        w_inexact  = w_guard | w_rs;
        w_round_up = w_guard & (w_rs | w_lsb);
        w_sig      = {1'b0, norm_mant[M+3:3]} + {{(M+1){1'b0}}, w_round_up};
        // Sign-extend so the post-rounding increment cannot wrap.
        w_exp_r    = {norm_exp[E+1], norm_exp} + {{(E+2){1'b0}}, w_sig[M+1]};
        w_frac     = w_sig[M+1] ? w_sig[M:1] : w_sig[M-1:0];
        w_ovf      = ~w_exp_r[E+2] & (w_exp_r[E+1:0] >= C_EXP_MAX);
        w_unf      = w_exp_r[E+2] | (w_exp_r == '0);
    end

    always_comb begin
        w_word  = '0;
        w_flags = 3'b000;
        case (special)
            C_SP_NORMAL: begin
                if (norm_mant == '0) begin
                    w_word  = '0;
                    w_flags = 3'b000;
                end else if (w_ovf) begin
                    w_word  = {norm_sign, {E{1'b1}}, {M{1'b0}}};
                    w_flags = 3'b101;
                end else if (w_unf) begin
                    w_word  = {norm_sign, {(W-1){1'b0}}};
                    w_flags = 3'b011;
                end else begin
                    w_word  = {norm_sign, w_exp_r[E-1:0], w_frac};
                    w_flags = {2'b00, w_inexact};
                end
            end
            C_SP_ZERO: begin
                w_word = {a_sign & b_sign, {(W-1){1'b0}}};
            end
            C_SP_INF: begin
                w_word = {a_is_inf ? a_sign : b_sign, {E{1'b1}}, {M{1'b0}}};
            end
            default: begin
                w_word = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
            end
        endcase
    end

    // 2-entry FIFO holding {flags, word}
    logic [W+2:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign in_ready  = (r_count < 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign {out_flags, result} = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_flags, w_word};
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire
